sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/slc3_pkg.sv | 25 ++
 rtl/sram_wait_timer.sv | 38 +++
 rtl/sram_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared types and widths for the SRAM arbiter block.
// States, bus owner encoding and the SRAM bus widths live here.
package slc3_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;
    localparam int WCNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // The requester that was not just granted.
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
    endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Access-length timer: cleared by load, counts while enabled and flags
// the final cycle of a WAIT_CYCLES-long access window.
module sram_wait_timer
    import slc3_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam logic [WCNT_W-1:0] LAST = WCNT_W'(WAIT_CYCLES - 1);

    logic [WCNT_W-1:0] cnt_q, cnt_d;

    assign done_o = en_i && (cnt_q == LAST);

    // Next count: clear on load, advance until the last access cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (en_i && !done_o)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single asynchronous SRAM.
// Each transfer: IDLE -> ACCESS (WAIT_CYCLES) -> DONE (ready pulse) -> IDLE.
// Optional macro SRAM_ARB_RR_EN swaps fixed CPU priority for round-robin.
module sram_arbiter
    import slc3_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [SRAM_AW-1:0]  cpu_addr,
    input  logic [SRAM_DW-1:0]  cpu_wdata,
    output logic [SRAM_DW-1:0]  cpu_rdata,
    output logic                cpu_ready,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [SRAM_AW-1:0]  dma_addr,
    input  logic [SRAM_DW-1:0]  dma_wdata,
    output logic [SRAM_DW-1:0]  dma_rdata,
    output logic                dma_ready,
    output logic [SRAM_AW-1:0]  ADDR,
    output logic [SRAM_DW-1:0]  Data_to_SRAM,
    input  logic [SRAM_DW-1:0]  Data_from_SRAM,
    output logic                Data_oe,
    output logic                Mem_CE,
    output logic                Mem_UB,
    output logic                Mem_LB,
    output logic                Mem_OE,
    output logic                Mem_WE
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, win;
    logic              we_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [SRAM_DW-1:0] wdata_q;
    logic [SRAM_DW-1:0] cpu_rdata_q, dma_rdata_q;
    logic              any_req, pick_dma, grant, tmr_done;

    assign any_req = cpu_req || dma_req;
    assign grant   = (state_q == IDLE) && any_req;
    assign win     = pick_dma ? OWN_DMA : OWN_CPU;

`ifdef SRAM_ARB_RR_EN
    owner_t rr_q;   // requester favoured on the next contested grant

    // Contested grants go to the pointer's favourite; otherwise whoever asks.
    always_comb begin
        pick_dma = dma_req;
        if (cpu_req && dma_req)
            pick_dma = (rr_q == OWN_DMA);
    end

    // After each grant, favour the requester that did not just win.
    always_ff @(posedge Clk) begin
        if (Reset)
            rr_q <= OWN_CPU;
        else if (grant)
            rr_q <= other_owner(win);
    end
`else
    // CPU always wins a simultaneous request.
    always_comb begin
        pick_dma = dma_req && !cpu_req;
    end
`endif

    sram_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .load_i (grant),
        .en_i   (state_q == ACCESS),
        .done_o (tmr_done)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: one access window, one completion cycle, back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)  state_d = ACCESS;
            ACCESS:  if (tmr_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transfer latch on grant, and read-data capture on the last access cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= win;
                we_q    <= pick_dma ? dma_we    : cpu_we;
                addr_q  <= pick_dma ? dma_addr  : cpu_addr;
                wdata_q <= pick_dma ? dma_wdata : cpu_wdata;
            end
            if ((state_q == ACCESS) && tmr_done && !we_q) begin
                if (owner_q == OWN_DMA)
                    dma_rdata_q <= Data_from_SRAM;
                else
                    cpu_rdata_q <= Data_from_SRAM;
            end
        end
    end

    // SRAM strobes and completion pulses decoded from the current state.
    always_comb begin
        ADDR         = '0;
        Data_to_SRAM = '0;
        Data_oe      = 1'b0;
        Mem_OE       = 1'b1;
        Mem_WE       = 1'b1;
        cpu_ready    = 1'b0;
        dma_ready    = 1'b0;
        case (state_q)
            ACCESS: begin
                ADDR = addr_q;
                if (we_q) begin
                    Mem_WE       = 1'b0;
                    Data_oe      = 1'b1;
                    Data_to_SRAM = wdata_q;
                end else begin
                    Mem_OE = 1'b0;
                end
            end
            DONE: begin
                ADDR      = addr_q;
                cpu_ready = (owner_q == OWN_CPU);
                dma_ready = (owner_q == OWN_DMA);
            end
            default: ;
        endcase
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign Mem_CE    = 1'b0;
    assign Mem_UB    = 1'b0;
    assign Mem_LB    = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: three instances (WAIT_CYCLES 2, 1, 7).
// Stimulus pushes the expected completion; a negedge monitor pops on each
// ready pulse and checks owner, cycle, data and the SRAM strobes seen.
module tb_sram_arbiter;

    typedef struct {
        int          id;
        bit          dma;
        int          cyc;
        bit          w;
        logic [19:0] a;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cpu_req, cpu_we, dma_req, dma_we;
    logic [19:0] cpu_addr [3];
    logic [19:0] dma_addr [3];
    logic [15:0] cpu_wdata [3];
    logic [15:0] dma_wdata [3];
    logic [15:0] sram_rd;
    logic [15:0] cpu_rdata [3];
    logic [15:0] dma_rdata [3];
    logic [15:0] dts [3];
    logic [19:0] addr_o [3];
    logic [2:0]  cpu_rdy, dma_rdy, doe, ce, ub, lb, oe, we;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 7;
        sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
            .Clk(clk), .Reset(rst),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_ready(cpu_rdy[g]),
            .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]),
            .dma_wdata(dma_wdata[g]), .dma_rdata(dma_rdata[g]), .dma_ready(dma_rdy[g]),
            .ADDR(addr_o[g]), .Data_to_SRAM(dts[g]), .Data_from_SRAM(sram_rd),
            .Data_oe(doe[g]), .Mem_CE(ce[g]), .Mem_UB(ub[g]), .Mem_LB(lb[g]),
            .Mem_OE(oe[g]), .Mem_WE(we[g])
        );
    end

    function automatic int wc(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 7;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push(input int i, input bit dma, input int c, input bit w,
                        input logic [19:0] a, input logic [15:0] d);
        exp_t e;
        e.id = i; e.dma = dma; e.cyc = c; e.w = w; e.a = a; e.d = d;
        sbq.push_back(e);
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Raise a request, hold it until the matching ready (bounded), then drop it.
    task automatic do_xfer(input int i, input bit dma, input bit w,
                           input logic [19:0] a, input logic [15:0] d);
        bit got;
        got = 1'b0;
        if (dma) begin
            dma_we[i] = w; dma_addr[i] = a; dma_wdata[i] = d; dma_req[i] = 1'b1;
        end else begin
            cpu_we[i] = w; cpu_addr[i] = a; cpu_wdata[i] = d; cpu_req[i] = 1'b1;
        end
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = dma ? dma_rdy[i] : cpu_rdy[i];
        end
        if (!got) begin
            n_chk++;
            $display("FAIL ready_timeout dut%0d dma=%0d: no ready, required within 40 cycles", i, dma);
        end
        @(posedge clk); #1;
        if (dma) dma_req[i] = 1'b0;
        else     cpu_req[i] = 1'b0;
    endtask

    // Monitor: strobe trackers per instance, scoreboard pop on every ready.
    int          oe_lo [3];
    int          we_lo [3];
    logic [19:0] s_addr [3];
    logic [15:0] s_wd [3];
    logic        s_doe [3];
    int          mk;
    exp_t        me;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                oe_lo[i] = 0; we_lo[i] = 0; s_addr[i] = '0; s_wd[i] = '0; s_doe[i] = 1'b0;
            end else begin
                if (!oe[i]) begin oe_lo[i]++; s_addr[i] = addr_o[i]; end
                if (!we[i]) begin
                    we_lo[i]++; s_addr[i] = addr_o[i]; s_wd[i] = dts[i]; s_doe[i] = doe[i];
                end
                if (cpu_rdy[i] || dma_rdy[i]) begin
                    mk = -1;
                    foreach (sbq[j]) if (mk < 0 && sbq[j].id == i) mk = j;
                    if (mk < 0) begin
                        n_chk++;
                        $display("FAIL unexpected_ready dut%0d: cpu_ready=%0d dma_ready=%0d, required none",
                                 i, cpu_rdy[i], dma_rdy[i]);
                    end else begin
                        me = sbq[mk];
                        sbq.delete(mk);
                        chk($sformatf("ready_owner dut%0d", i), {cpu_rdy[i], dma_rdy[i]},
                            me.dma ? 32'd1 : 32'd2);
                        chk($sformatf("ready_cycle dut%0d", i), cyc, me.cyc);
                        chk($sformatf("access_addr dut%0d", i), s_addr[i], me.a);
                        chk($sformatf("done_addr dut%0d", i), addr_o[i], me.a);
                        if (me.w) begin
                            chk($sformatf("we_low_cycles dut%0d", i), we_lo[i], wc(i));
                            chk($sformatf("oe_low_cycles dut%0d", i), oe_lo[i], 0);
                            chk($sformatf("wdata_bus dut%0d", i), s_wd[i], me.d);
                            chk($sformatf("data_oe dut%0d", i), s_doe[i], 1);
                        end else begin
                            chk($sformatf("oe_low_cycles dut%0d", i), oe_lo[i], wc(i));
                            chk($sformatf("we_low_cycles dut%0d", i), we_lo[i], 0);
                            chk($sformatf("rdata dut%0d", i),
                                me.dma ? dma_rdata[i] : cpu_rdata[i], me.d);
                        end
                    end
                    oe_lo[i] = 0; we_lo[i] = 0; s_addr[i] = '0; s_wd[i] = '0; s_doe[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        rst = 1'b1;
        cpu_req = '0; cpu_we = '0; dma_req = '0; dma_we = '0; sram_rd = '0;
        for (int i = 0; i < 3; i++) begin
            cpu_addr[i] = '0; dma_addr[i] = '0; cpu_wdata[i] = '0; dma_wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ctl dut%0d", i),
                {oe[i], we[i], doe[i], cpu_rdy[i], dma_rdy[i], ce[i], ub[i], lb[i]}, 32'hC0);
            chk($sformatf("rst_addr dut%0d", i), addr_o[i], 0);
            chk($sformatf("rst_rdata dut%0d", i), {cpu_rdata[i], dma_rdata[i]}, 0);
        end
        sync();
        rst = 1'b0;

        // CPU read, WAIT_CYCLES=2
        sync(); sram_rd = 16'h1234;
        push(0, 0, cyc + 3, 0, 20'h00010, 16'h1234);
        do_xfer(0, 0, 0, 20'h00010, 16'h0000);

        // DMA write, WAIT_CYCLES=2; CPU read data must hold
        sync();
        push(0, 1, cyc + 3, 1, 20'h0FFFF, 16'hBEEF);
        do_xfer(0, 1, 1, 20'h0FFFF, 16'hBEEF);
        chk("cpu_rdata_hold_after_write", cpu_rdata[0], 16'h1234);

        // Simultaneous requests: CPU first, DMA four cycles later
        sync(); sram_rd = 16'hA5A5; n0 = cyc;
        push(0, 0, n0 + 3, 0, 20'h00100, 16'hA5A5);
        push(0, 1, n0 + 7, 1, 20'h00200, 16'h5A5A);
        fork
            do_xfer(0, 0, 0, 20'h00100, 16'h0000);
            do_xfer(0, 1, 1, 20'h00200, 16'h5A5A);
        join

        // DMA read leaves CPU read data alone
        sync(); sram_rd = 16'h7E57;
        push(0, 1, cyc + 3, 0, 20'h00ABC, 16'h7E57);
        do_xfer(0, 1, 0, 20'h00ABC, 16'h0000);
        chk("cpu_rdata_hold_after_dma_read", cpu_rdata[0], 16'hA5A5);

        // Shortest and longest access windows
        sync(); sram_rd = 16'h1111;
        push(1, 0, cyc + 2, 0, 20'h00001, 16'h1111);
        do_xfer(1, 0, 0, 20'h00001, 16'h0000);
        sync();
        push(1, 1, cyc + 2, 1, 20'h00002, 16'h2222);
        do_xfer(1, 1, 1, 20'h00002, 16'h2222);
        sync(); sram_rd = 16'h7777;
        push(2, 0, cyc + 8, 0, 20'hFFFFF, 16'h7777);
        do_xfer(2, 0, 0, 20'hFFFFF, 16'h0000);

        // Both requests held across four transfers
        sync(); sram_rd = 16'h0F0F; n0 = cyc;
        cpu_we[0] = 1'b0; cpu_addr[0] = 20'h00300;
        dma_we[0] = 1'b0; dma_addr[0] = 20'h00400;
`ifdef SRAM_ARB_RR_EN
        push(0, 0, n0 + 3,  0, 20'h00300, 16'h0F0F);
        push(0, 1, n0 + 7,  0, 20'h00400, 16'h0F0F);
        push(0, 0, n0 + 11, 0, 20'h00300, 16'h0F0F);
        push(0, 1, n0 + 15, 0, 20'h00400, 16'h0F0F);
`else
        push(0, 0, n0 + 3,  0, 20'h00300, 16'h0F0F);
        push(0, 0, n0 + 7,  0, 20'h00300, 16'h0F0F);
        push(0, 0, n0 + 11, 0, 20'h00300, 16'h0F0F);
        push(0, 0, n0 + 15, 0, 20'h00300, 16'h0F0F);
        push(0, 1, n0 + 19, 0, 20'h00400, 16'h0F0F);
`endif
        cpu_req[0] = 1'b1; dma_req[0] = 1'b1;
        for (int t = 0; t < 40 && cyc < n0 + 15; t++) @(negedge clk);
        sync();
        cpu_req[0] = 1'b0;
`ifdef SRAM_ARB_RR_EN
        dma_req[0] = 1'b0;
`else
        for (int t = 0; t < 40 && cyc < n0 + 19; t++) @(negedge clk);
        sync();
        dma_req[0] = 1'b0;
`endif

        // Reset during the first access cycle of a write
        sync();
        dma_we[0] = 1'b1; dma_addr[0] = 20'h00055; dma_wdata[0] = 16'hDEAD; dma_req[0] = 1'b1;
        sync();
        rst = 1'b1; dma_req[0] = 1'b0;
        @(negedge clk);
        chk("we_low_before_reset", we[0], 0);
        sync();
        @(negedge clk);
        chk("rst_mid_we", we[0], 1);
        chk("rst_mid_oe_doe", {oe[0], doe[0]}, 2'b10);
        chk("rst_mid_addr", addr_o[0], 0);
        chk("rst_mid_ready", {cpu_rdy[0], dma_rdy[0]}, 0);
        chk("rst_mid_rdata", cpu_rdata[0], 0);
        sync();
        rst = 1'b0;
        repeat (6) @(posedge clk);

        // Normal service after the interrupted write
        sync(); sram_rd = 16'h4242;
        push(0, 0, cyc + 3, 0, 20'h00020, 16'h4242);
        do_xfer(0, 0, 0, 20'h00020, 16'h0000);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
